// File: rtl/d_ff_pipe_pkg.sv
// d_ff_pipe_pkg
//   Shared definitions for the d_ff_pipe pipeline register:
//   - PIPE_RESET_VAL : default reset/flush data value
//   - stage_op_e     : per-edge action of one pipeline stage
//   - occ_width()    : width of the occupancy counter for a given depth
//   - stage_op()     : r > flush > en > hold priority decode
package d_ff_pipe_pkg;

   localparam logic [31:0] PIPE_RESET_VAL = 32'h0000_0000;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_FLUSH = 2'd2,
      OP_RESET = 2'd3
   } stage_op_e;

   // Enough bits to count 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      if (depth < 2) return 1;
      return $clog2(depth + 1);
   endfunction

   function automatic stage_op_e stage_op(input logic r, input logic flush, input logic en);
      if (r)          return OP_RESET;
      else if (flush) return OP_FLUSH;
      else if (en)    return OP_LOAD;
      else            return OP_HOLD;
   endfunction

endpackage

// File: rtl/d_ff_pipe_if.sv
// d_ff_pipe_if
//   Bundles the pipeline control, input and output signals.
//   master : drives en, flush, d, d_valid; observes q, q_valid, occupancy, busy
//   slave  : the pipeline itself
interface d_ff_pipe_if
   import d_ff_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned OCC_W = occ_width(DEPTH);

   logic             en;
   logic             flush;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic [OCC_W-1:0] occupancy;
   logic             busy;

   modport master (
      output en, flush, d, d_valid,
      input  q, q_valid, occupancy, busy
   );

   modport slave (
      input  en, flush, d, d_valid,
      output q, q_valid, occupancy, busy
   );

endinterface

// File: rtl/d_ff_pipe_stage.sv
// d_ff_pipe_stage
//   One data + valid register of the pipeline.
//   Per rising edge: r loads RESET_VAL/invalid, flush invalidates (and clears
//   data to RESET_VAL when FLUSH_DATA=1), en captures d/d_valid, else hold.
// Ports
//   clk, r            clock, synchronous active-high reset
//   en, flush         advance enable, synchronous kill
//   d, d_valid        entry from the previous stage (or pipeline input)
//   q, q_valid        registered entry
module d_ff_pipe_stage
   import d_ff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter bit               FLUSH_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             r,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid
);

   stage_op_e op;

   assign op = stage_op(r, flush, en);

   always_ff @(posedge clk) begin
      case (op)
         OP_RESET: begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
         end
         OP_FLUSH: begin
            if (FLUSH_DATA) q <= RESET_VAL;
            q_valid <= 1'b0;
         end
         OP_LOAD: begin
            q       <= d;
            q_valid <= d_valid;
         end
         OP_HOLD: begin
            q       <= q;
            q_valid <= q_valid;
         end
         default: begin
            q       <= q;
            q_valid <= q_valid;
         end
      endcase
   end

endmodule

// File: rtl/d_ff_pipe.sv
// d_ff_pipe
//   DEPTH-stage pipeline register of WIDTH-bit data with per-stage valid bits,
//   global stall (en=0), flush and a registered occupancy counter.
// Ports
//   clk                 rising-edge clock
//   r                   synchronous active-high reset
//   bus (slave)         en, flush, d, d_valid in; q, q_valid, occupancy, busy out
module d_ff_pipe
   import d_ff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(PIPE_RESET_VAL),
   parameter bit               FLUSH_DATA = 1'b1
) (
   input  logic        clk,
   input  logic        r,
   d_ff_pipe_if.slave  bus
);

   localparam int unsigned OCC_W = occ_width(DEPTH);

   // Index 0 is the pipeline input, index DEPTH the last stage.
   logic [DEPTH:0][WIDTH-1:0] data;
   logic [DEPTH:0]            vld;

   assign data[0] = bus.d;
   assign vld[0]  = bus.d_valid;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      d_ff_pipe_stage #(
         .WIDTH      (WIDTH),
         .RESET_VAL  (RESET_VAL),
         .FLUSH_DATA (FLUSH_DATA)
      ) u_stage (
         .clk     (clk),
         .r       (r),
         .en      (bus.en),
         .flush   (bus.flush),
         .d       (data[i]),
         .d_valid (vld[i]),
         .q       (data[i+1]),
         .q_valid (vld[i+1])
      );
   end

   assign bus.q       = data[DEPTH];
   assign bus.q_valid = vld[DEPTH];

   // Occupancy is tracked incrementally rather than by popcount: an entry
   // enters when d_valid is captured and leaves when the last stage's valid
   // is overwritten. Modular arithmetic keeps the +1/-1 case exact.
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;

   always_comb begin
      occ_nxt = occ;
      if (r || bus.flush)
         occ_nxt = '0;
      else if (bus.en)
         occ_nxt = occ + OCC_W'(bus.d_valid) - OCC_W'(vld[DEPTH]);
   end

   always_ff @(posedge clk) begin
      occ <= occ_nxt;
   end

   assign bus.occupancy = occ;
   assign bus.busy      = (occ != '0);

   a_occ_no_overflow: assert property (@(posedge clk) disable iff (r)
      (bus.en && !bus.flush) |->
         (int'(occ) + int'(bus.d_valid) <= int'(DEPTH) + int'(vld[DEPTH])));

   a_occ_no_underflow: assert property (@(posedge clk) disable iff (r)
      (bus.en && !bus.flush) |->
         (int'(occ) + int'(bus.d_valid) >= int'(vld[DEPTH])));

   a_occ_in_range: assert property (@(posedge clk) disable iff (r)
      int'(occ) <= int'(DEPTH));

endmodule

// File: tb/tb_d_ff_pipe.sv
module tb_d_ff_pipe;

   logic clk = 1'b0;
   logic r   = 1'b1;

   always #5 clk = ~clk;

   d_ff_pipe_if #(.WIDTH(8), .DEPTH(3)) if_a ();
   d_ff_pipe_if #(.WIDTH(8), .DEPTH(3)) if_b ();
   d_ff_pipe_if #(.WIDTH(8), .DEPTH(1)) if_c ();

   d_ff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .FLUSH_DATA(1'b1))
      u_a (.clk(clk), .r(r), .bus(if_a.slave));
   d_ff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .FLUSH_DATA(1'b0))
      u_b (.clk(clk), .r(r), .bus(if_b.slave));
   d_ff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5), .FLUSH_DATA(1'b1))
      u_c (.clk(clk), .r(r), .bus(if_c.slave));

   typedef struct {
      int         sel;
      logic [7:0] q;
      logic       qv;
      int         occ;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Drive one cycle of stimulus (same inputs to all three DUTs) and queue the
   // hand-computed outputs expected from the selected DUT after the next edge.
   task automatic step(input int sel, input bit rr, input bit e, input bit f,
                       input logic [7:0] dd, input bit dv,
                       input logic [7:0] eq, input bit eqv, input int eocc,
                       input string nm);
      exp_t x;
      @(negedge clk);
      r = rr;
      if_a.en = e; if_a.flush = f; if_a.d = dd; if_a.d_valid = dv;
      if_b.en = e; if_b.flush = f; if_b.d = dd; if_b.d_valid = dv;
      if_c.en = e; if_c.flush = f; if_c.d = dd; if_c.d_valid = dv;
      x.sel = sel; x.q = eq; x.qv = eqv; x.occ = eocc; x.name = nm;
      sb.push_back(x);
   endtask

   // Monitor: one expected record per clock edge, checked just after the edge.
   always @(posedge clk) begin
      exp_t x;
      int   aq, aqv, aocc, abusy;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         case (x.sel)
            0: begin aq = int'(if_a.q); aqv = int'(if_a.q_valid); aocc = int'(if_a.occupancy); abusy = int'(if_a.busy); end
            1: begin aq = int'(if_b.q); aqv = int'(if_b.q_valid); aocc = int'(if_b.occupancy); abusy = int'(if_b.busy); end
            default: begin aq = int'(if_c.q); aqv = int'(if_c.q_valid); aocc = int'(if_c.occupancy); abusy = int'(if_c.busy); end
         endcase
         check({x.name, ".q"},    aq,    int'(x.q));
         check({x.name, ".qv"},   aqv,   int'(x.qv));
         check({x.name, ".occ"},  aocc,  x.occ);
         check({x.name, ".busy"}, abusy, (x.occ != 0) ? 1 : 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.en = 1'b0; if_a.flush = 1'b0; if_a.d = '0; if_a.d_valid = 1'b0;
      if_b.en = 1'b0; if_b.flush = 1'b0; if_b.d = '0; if_b.d_valid = 1'b0;
      if_c.en = 1'b0; if_c.flush = 1'b0; if_c.d = '0; if_c.d_valid = 1'b0;

      //    sel r  en fl d      dv  q      qv occ name
      // DUT A: DEPTH=3, FLUSH_DATA=1
      step(0, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "a_rst0");
      step(0, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "a_rst1");
      // latency
      step(0, 0, 1, 0, 8'h01, 1, 8'hA5, 0, 1, "a_lat1");
      step(0, 0, 1, 0, 8'h02, 1, 8'hA5, 0, 2, "a_lat2");
      step(0, 0, 1, 0, 8'h03, 1, 8'h01, 1, 3, "a_lat3");
      step(0, 0, 1, 0, 8'h04, 1, 8'h02, 1, 3, "a_lat4");
      step(0, 0, 1, 0, 8'h00, 0, 8'h03, 1, 2, "a_lat5");
      step(0, 0, 1, 0, 8'h00, 0, 8'h04, 1, 1, "a_lat6");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "a_lat7");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "a_lat8");
      // stall
      step(0, 0, 1, 0, 8'h11, 1, 8'h00, 0, 1, "a_stl1");
      step(0, 0, 1, 0, 8'h22, 1, 8'h00, 0, 2, "a_stl2");
      step(0, 0, 1, 0, 8'h33, 1, 8'h11, 1, 3, "a_stl3");
      step(0, 0, 0, 0, 8'hAA, 1, 8'h11, 1, 3, "a_hold1");
      step(0, 0, 0, 0, 8'hBB, 1, 8'h11, 1, 3, "a_hold2");
      step(0, 0, 0, 0, 8'hCC, 0, 8'h11, 1, 3, "a_hold3");
      step(0, 0, 0, 0, 8'hDD, 1, 8'h11, 1, 3, "a_hold4");
      step(0, 0, 1, 0, 8'h00, 0, 8'h22, 1, 2, "a_res1");
      step(0, 0, 1, 0, 8'h00, 0, 8'h33, 1, 1, "a_res2");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "a_res3");
      // flush, data cleared
      step(0, 0, 1, 0, 8'h55, 1, 8'h00, 0, 1, "a_fil1");
      step(0, 0, 1, 0, 8'h66, 1, 8'h00, 0, 2, "a_fil2");
      step(0, 0, 1, 0, 8'h77, 1, 8'h55, 1, 3, "a_fil3");
      step(0, 0, 1, 1, 8'h44, 1, 8'hA5, 0, 0, "a_flush");
      step(0, 0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, "a_post1");
      step(0, 0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, "a_post2");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "a_post3");
      // bubbles
      step(0, 0, 1, 0, 8'h81, 1, 8'h00, 0, 1, "a_bub1");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "a_bub2");
      step(0, 0, 1, 0, 8'h83, 1, 8'h81, 1, 2, "a_bub3");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "a_bub4");
      step(0, 0, 1, 0, 8'h85, 1, 8'h83, 1, 2, "a_bub5");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "a_bub6");
      step(0, 0, 1, 0, 8'h00, 0, 8'h85, 1, 1, "a_bub7");
      step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "a_bub8");
      // priority: r+flush, then flush while stalled
      step(0, 0, 1, 0, 8'h99, 1, 8'h00, 0, 1, "a_pri1");
      step(0, 1, 1, 1, 8'h9A, 1, 8'hA5, 0, 0, "a_rstfl");
      step(0, 0, 1, 0, 8'h9B, 1, 8'hA5, 0, 1, "a_pri2");
      step(0, 0, 0, 1, 8'h9C, 1, 8'hA5, 0, 0, "a_flstall");
      step(0, 0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, "a_pri3");
      step(0, 0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, "a_pri4");

      // DUT B: DEPTH=3, FLUSH_DATA=0
      step(1, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "b_rst0");
      step(1, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "b_rst1");
      step(1, 0, 1, 0, 8'h55, 1, 8'hA5, 0, 1, "b_fil1");
      step(1, 0, 1, 0, 8'h66, 1, 8'hA5, 0, 2, "b_fil2");
      step(1, 0, 1, 0, 8'h77, 1, 8'h55, 1, 3, "b_fil3");
      step(1, 0, 1, 1, 8'h44, 1, 8'h55, 0, 0, "b_flush");
      step(1, 0, 1, 0, 8'h00, 0, 8'h66, 0, 0, "b_post1");
      step(1, 0, 1, 0, 8'h00, 0, 8'h77, 0, 0, "b_post2");
      step(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "b_post3");
      step(1, 0, 1, 0, 8'h88, 1, 8'h00, 0, 1, "b_pri1");
      step(1, 1, 1, 1, 8'h89, 1, 8'hA5, 0, 0, "b_rstfl");
      step(1, 0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, "b_pri2");

      // DUT C: DEPTH=1
      step(2, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "c_rst0");
      step(2, 1, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "c_rst1");
      step(2, 0, 1, 0, 8'h5A, 1, 8'h5A, 1, 1, "c_lat1");
      step(2, 0, 1, 0, 8'h5B, 1, 8'h5B, 1, 1, "c_lat2");
      step(2, 0, 1, 0, 8'h5C, 1, 8'h5C, 1, 1, "c_lat3");
      step(2, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "c_drain");
      step(2, 0, 1, 0, 8'h66, 1, 8'h66, 1, 1, "c_stl1");
      step(2, 0, 0, 0, 8'h77, 1, 8'h66, 1, 1, "c_hold");
      step(2, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, "c_stl2");
      step(2, 0, 1, 0, 8'h12, 1, 8'h12, 1, 1, "c_fil");
      step(2, 0, 1, 1, 8'h34, 1, 8'hA5, 0, 0, "c_flush");

      @(posedge clk);
      #3;
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
